pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
- Hardware performance/trace monitor attached beside the 5-stage pipelined CPU.
- Consumes the CPU's per-cycle hazard-detect, jump/branch, flush, PC and retire signals.
- Produces saturating event counters, a cycle-limit halt, and a FIFO of PCs captured on flush events.
- Replaces bench-side stall/flush bookkeeping with in-design counters readable over a simple request/ack port.

Parameters:
CNT_W, 32, width of every event counter and rd_data_o
MAX_CYCLES, 20, RUN cycles before automatic halt; 0 = never halt
TRACE_DEPTH, 8, flush-PC FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  CPU start; level, high = CPU running
clear_i  in  1  synchronous clear pulse
stall_i  in  1  hazard-detect stall request from CPU
jump_i  in  1  decode stage jump control
branch_i  in  1  decode stage branch control
flush_i  in  1  IF/ID flush from CPU
pc_i  in  32  current PC register output
retire_i  in  1  valid instruction completing WB this cycle
rd_req_i  in  1  counter read request (level)
rd_sel_i  in  3  counter select
rd_ack_o  out  1  one-cycle read acknowledge
rd_data_o  out  CNT_W  read data, valid while rd_ack_o high
halt_o  out  1  high in HALTED
state_o  out  2  0 IDLE, 1 RUN, 2 HALTED
trace_pop_i  in  1  pop FIFO head
trace_pc_o  out  32  FIFO head PC (show-ahead)
trace_valid_o  out  1  FIFO non-empty

Behaviour:
- Reset (async): state IDLE; all counters, FIFO pointers and count = 0; rd_ack_o=0, rd_data_o=0, halt_o=0, trace_valid_o=0, trace_pc_o=0.
- Priority per edge: rst_i > clear_i > everything else. clear_i zeroes counters, empties FIFO, state->IDLE, and kills any pending ack (rd_ack_o=0 next cycle).
- FSM:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0; counters hold.
  - RUN -> HALTED on the edge where cycle_cnt == MAX_CYCLES-1 (MAX_CYCLES!=0). That edge still counts, so cycle_cnt = MAX_CYCLES in HALTED.
  - HALTED is left only by rst_i or clear_i.
- Events are sampled only in RUN, including the RUN->HALTED edge:
  - cycle_cnt +1 every RUN cycle.
  - stall_cnt +1 when stall_i & ~jump_i & ~branch_i.
  - flush_cnt +1 when flush_i.
  - retire_cnt +1 when retire_i.
- All counters saturate at 2^CNT_W-1; no wrap.
- halt_o is registered and equals (state==HALTED).
- Readout:
  - Request is accepted on an edge with rd_req_i=1 and rd_ack_o=0.
  - Next cycle: rd_ack_o=1 and rd_data_o = selected value, snapshotted at acceptance.
  - A held rd_req_i therefore yields an ack every second cycle.
  - rd_data_o holds its last value when ack is low.
  - sel 0 cycle, 1 stall, 2 flush, 3 retire, 4 trace_drop, 5 {state, FIFO count} zero-extended, 6-7 return 0.
  - Reads work in every state.
- Trace FIFO:
  - Push pc_i when RUN & flush_i. Pop when trace_pop_i & non-empty; pop on empty is ignored.
  - Push and pop in the same cycle both happen, including when full; no drop.
  - Push when full without a pop: entry discarded, trace_drop +1 (saturating).
  - Pointers wrap modulo TRACE_DEPTH.
  - trace_pc_o shows the head entry whenever trace_valid_o=1; 0 when empty.

Test Plan:
1. Reset, start_i=1 at cycle 1, no events, MAX_CYCLES=20 -> state RUN, after 20 edges halt_o=1, state_o=2; read sel0 -> 20; further edges leave it at 20.
2. In RUN drive stall_i=1 for 3 cycles, one of them with branch_i=1; flush_i=1 for 2 cycles -> sel1 = 2, sel2 = 2.
3. Drive 9 flushes with PCs 0x04..0x24 step 4, no pops, TRACE_DEPTH=8 -> sel4 = 1, trace_pc_o=0x04. Pop 8 times -> PCs 0x04..0x20 in order, then trace_valid_o=0.
4. FIFO full with a simultaneous flush and pop -> count stays 8, sel4 unchanged, new PC becomes the tail.
5. Hold rd_req_i=1, sel=3 with retire_cnt=5 -> rd_ack_o pulses 1,0,1,0 with rd_data_o=5; clear_i in the ack cycle -> next cycle counters 0, state IDLE, rd_ack_o=0.
6. Assert rst_i mid-RUN, asynchronously between edges -> outputs zero immediately without a clock edge; state_o=0.

Source files
------------

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline performance counters, cycle-limit halt and flush-PC trace FIFO
//
// Purpose:
//   Sits beside the 5-stage CPU and watches its hazard, control-flow, flush,
//   PC and retire signals. Keeps saturating event counters, stops counting
//   after MAX_CYCLES RUN cycles, and records the PC of every flush in a small
//   show-ahead FIFO.
//
// Ports:
//   clk_i, rst_i         clock / asynchronous active-high reset
//   start_i              CPU running level (IDLE <-> RUN)
//   clear_i              synchronous clear of counters, FIFO, state and read ack
//   stall_i, jump_i,
//   branch_i, flush_i,
//   retire_i, pc_i       CPU event inputs, sampled only in RUN
//   rd_req_i, rd_sel_i   counter read request / select
//   rd_ack_o, rd_data_o  one-cycle read acknowledge with snapshotted data
//   halt_o, state_o      registered halt flag and current state
//   trace_pop_i          pop the FIFO head
//   trace_pc_o           FIFO head PC, 0 when empty
//   trace_valid_o        FIFO non-empty

module pipe_perf_monitor #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 20,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             retire_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             halt_o,
    output logic [1:0]       state_o,
    input  logic             trace_pop_i,
    output logic [31:0]      trace_pc_o,
    output logic             trace_valid_o
);

    localparam int unsigned      AW      = $clog2(TRACE_DEPTH);
    localparam int unsigned      LIMIT   = (MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             halt_q;

    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] drop_cnt;

    logic [31:0]      trace_mem [TRACE_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_cnt;

    logic             run;
    logic             limit_hit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             push_write;
    logic             drop;

    logic             ack_q;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] sel_val;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign run       = (state_q == ST_RUN);
    // The limit edge itself is still a RUN cycle, so cycle_cnt ends at MAX_CYCLES.
    assign limit_hit = (MAX_CYCLES != 0) && (cycle_cnt == CNT_W'(LIMIT));

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (limit_hit) begin
                    state_d = ST_HALTED;
                end else if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
        end
    end

    // halt_q tracks the next state so that it always equals (state_q == HALTED).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == ST_HALTED);
        end
    end

    // ------------------------------------------------------------------
    // Trace FIFO control
    // ------------------------------------------------------------------
    assign empty      = (fifo_cnt == '0);
    assign full       = (fifo_cnt == (AW+1)'(TRACE_DEPTH));
    assign push       = run & flush_i;
    assign pop        = trace_pop_i & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_write = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (push_write && !clear_i && !rst_i) begin
            trace_mem[wr_ptr] <= pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_write, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
        end else if (clear_i) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (run) begin
                cycle_cnt <= sat_inc(cycle_cnt);
                // A stall raised alongside a jump/branch is a control redirect, not a data hazard.
                if (stall_i && !jump_i && !branch_i) begin
                    stall_cnt <= sat_inc(stall_cnt);
                end
                if (flush_i) begin
                    flush_cnt <= sat_inc(flush_cnt);
                end
                if (retire_i) begin
                    retire_cnt <= sat_inc(retire_cnt);
                end
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout: a request is taken only while no ack is showing, which makes
    // a held request acknowledge every second cycle.
    // ------------------------------------------------------------------
    assign accept = rd_req_i & ~ack_q;

    always_comb begin
        sel_val = '0;
        case (rd_sel_i)
            3'd0:    sel_val = cycle_cnt;
            3'd1:    sel_val = stall_cnt;
            3'd2:    sel_val = flush_cnt;
            3'd3:    sel_val = retire_cnt;
            3'd4:    sel_val = drop_cnt;
            3'd5:    sel_val = CNT_W'({state_q, fifo_cnt});
            default: sel_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            ack_q  <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                data_q <= sel_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_ack_o      = ack_q;
    assign rd_data_o     = data_q;
    assign halt_o        = halt_q;
    assign state_o       = state_q;
    assign trace_valid_o = ~empty;
    assign trace_pc_o    = empty ? 32'd0 : trace_mem[rd_ptr];

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - self-checking bench for pipe_perf_monitor

module tb_pipe_perf_monitor;

    localparam int     CNT_W      = 32;
    localparam int     MAX_CYCLES = 20;
    localparam int     DEPTH      = 8;
    localparam longint SAT        = (longint'(1) << CNT_W) - 1;

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b1;
    logic             start_i     = 1'b0;
    logic             clear_i     = 1'b0;
    logic             stall_i     = 1'b0;
    logic             jump_i      = 1'b0;
    logic             branch_i    = 1'b0;
    logic             flush_i     = 1'b0;
    logic [31:0]      pc_i        = '0;
    logic             retire_i    = 1'b0;
    logic             rd_req_i    = 1'b0;
    logic [2:0]       rd_sel_i    = '0;
    logic             trace_pop_i = 1'b0;
    logic             rd_ack_o;
    logic [CNT_W-1:0] rd_data_o;
    logic             halt_o;
    logic [1:0]       state_o;
    logic [31:0]      trace_pc_o;
    logic             trace_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_state;
    longint      m_cyc, m_stall, m_flush, m_ret, m_drop, m_data;
    bit          m_ack;
    logic [31:0] m_q[$];

    pipe_perf_monitor #(
        .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .stall_i(stall_i), .jump_i(jump_i), .branch_i(branch_i), .flush_i(flush_i),
        .pc_i(pc_i), .retire_i(retire_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
        .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o), .halt_o(halt_o), .state_o(state_o),
        .trace_pop_i(trace_pop_i), .trace_pc_o(trace_pc_o), .trace_valid_o(trace_valid_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic longint sel_val(input int sel);
        case (sel)
            0:       return m_cyc;
            1:       return m_stall;
            2:       return m_flush;
            3:       return m_ret;
            4:       return m_drop;
            5:       return longint'(m_state) * 16 + m_q.size();
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        m_state = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_ret = 0; m_drop = 0;
        m_ack = 0;
        m_q.delete();
    endtask

    task automatic model_reset();
        model_clear();
        m_data = 0;
    endtask

    task automatic compare_all();
        check("state", state_o, m_state);
        check("halt", halt_o, (m_state == 2));
        check("ack", rd_ack_o, m_ack);
        check("rdata", rd_data_o, m_data);
        check("tvalid", trace_valid_o, (m_q.size() > 0));
        check("tpc", trace_pc_o, (m_q.size() > 0) ? m_q[0] : 32'd0);
    endtask

    // Advance one clock: model applies the rules to the inputs currently driven.
    task automatic tick();
        int nstate;
        bit acc, do_pop, do_push;
        nstate = m_state;
        if (clear_i) begin
            model_clear();
        end else begin
            acc = rd_req_i && !m_ack;
            if (acc) m_data = sel_val(rd_sel_i);
            m_ack = acc;
            do_pop  = trace_pop_i && (m_q.size() > 0);
            do_push = (m_state == 1) && flush_i;
            if (do_push && m_q.size() == DEPTH && !do_pop) m_drop = sat(m_drop);
            if (do_pop) void'(m_q.pop_front());
            if (do_push && m_q.size() < DEPTH) m_q.push_back(pc_i);
            if (m_state == 1) begin
                if (MAX_CYCLES != 0 && m_cyc == MAX_CYCLES - 1) nstate = 2;
                else if (!start_i) nstate = 0;
                m_cyc = sat(m_cyc);
                if (stall_i && !jump_i && !branch_i) m_stall = sat(m_stall);
                if (flush_i) m_flush = sat(m_flush);
                if (retire_i) m_ret = sat(m_ret);
            end else if (m_state == 0 && start_i) begin
                nstate = 1;
            end
            m_state = nstate;
        end
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic read_expect(input string tag, input logic [2:0] sel, input longint exp);
        rd_req_i = 1'b0;
        tick();
        rd_req_i = 1'b1;
        rd_sel_i = sel;
        tick();
        rd_req_i = 1'b0;
        check({tag, "_ack"}, rd_ack_o, 1);
        check(tag, rd_data_o, exp);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: free-running until the cycle limit halts the monitor
        tick();
        start_i = 1'b1;
        tick();
        check("t1_run", state_o, 1);
        for (int i = 0; i < MAX_CYCLES; i++) tick();
        check("t1_halt", halt_o, 1);
        check("t1_state", state_o, 2);
        for (int i = 0; i < 3; i++) tick();
        read_expect("t1_cyc", 3'd0, MAX_CYCLES);

        // 2: stalls (one masked by branch) and flushes
        do_clear();
        tick();
        stall_i = 1'b1; tick();
        branch_i = 1'b1; tick();
        branch_i = 1'b0; tick();
        stall_i = 1'b0;
        flush_i = 1'b1; pc_i = 32'h40; tick();
        pc_i = 32'h44; tick();
        flush_i = 1'b0; start_i = 1'b0; tick();
        read_expect("t2_stall", 3'd1, 2);
        read_expect("t2_flush", 3'd2, 2);

        // 3: overflow the trace FIFO by one, then drain it
        do_clear();
        start_i = 1'b1; tick();
        for (int i = 1; i <= 9; i++) begin
            flush_i = 1'b1; pc_i = 32'(4 * i); tick();
        end
        flush_i = 1'b0; start_i = 1'b0; tick();
        read_expect("t3_drop", 3'd4, 1);
        check("t3_head", trace_pc_o, 32'h04);
        for (int i = 1; i <= 8; i++) begin
            check("t3_popv", trace_valid_o, 1);
            check("t3_poppc", trace_pc_o, 32'(4 * i));
            trace_pop_i = 1'b1; tick();
        end
        trace_pop_i = 1'b0;
        check("t3_empty", trace_valid_o, 0);

        // 4: full FIFO with simultaneous push and pop
        do_clear();
        start_i = 1'b1; tick();
        for (int i = 0; i < 8; i++) begin
            flush_i = 1'b1; pc_i = 32'h100 + 32'(4 * i); tick();
        end
        pc_i = 32'h200; trace_pop_i = 1'b1; tick();
        flush_i = 1'b0; trace_pop_i = 1'b0; start_i = 1'b0; tick();
        read_expect("t4_cnt", 3'd5, 8);
        read_expect("t4_drop", 3'd4, 0);
        for (int i = 0; i < 8; i++) begin
            trace_pop_i = 1'b1; tick();
        end
        trace_pop_i = 1'b0;
        check("t4_empty", trace_valid_o, 0);

        // 5: held read request, then clear during an ack cycle
        do_clear();
        start_i = 1'b1; tick();
        retire_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        retire_i = 1'b0; start_i = 1'b0; tick();
        rd_req_i = 1'b1; rd_sel_i = 3'd3;
        tick(); check("t5_ack1", rd_ack_o, 1); check("t5_data1", rd_data_o, 5);
        tick(); check("t5_ack2", rd_ack_o, 0); check("t5_data2", rd_data_o, 5);
        tick(); check("t5_ack3", rd_ack_o, 1);
        tick(); check("t5_ack4", rd_ack_o, 0);
        tick(); check("t5_ack5", rd_ack_o, 1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check("t5_clr_ack", rd_ack_o, 0);
        check("t5_clr_state", state_o, 0);
        rd_req_i = 1'b0;
        read_expect("t5_ret0", 3'd3, 0);

        // 6: asynchronous reset between edges
        start_i = 1'b1; tick();
        flush_i = 1'b1; pc_i = 32'h300; tick(); tick();
        flush_i = 1'b0; rd_req_i = 1'b1; rd_sel_i = 3'd0; tick();
        rd_req_i = 1'b0;
        check("t6_pre_valid", trace_valid_o, 1);
        #2;
        rst_i = 1'b1;
        start_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_state", state_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            start_i     = ($urandom_range(0, 9) != 0);
            clear_i     = ($urandom_range(0, 29) == 0);
            stall_i     = ($urandom_range(0, 2) == 0);
            jump_i      = ($urandom_range(0, 3) == 0);
            branch_i    = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 1) == 0);
            retire_i    = ($urandom_range(0, 1) == 0);
            trace_pop_i = ($urandom_range(0, 2) == 0);
            rd_req_i    = ($urandom_range(0, 1) == 0);
            rd_sel_i    = 3'($urandom_range(0, 7));
            pc_i        = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
